// File: rtl/testro_pio_pkg.sv
// Shared constants for the TestRO PIO blocks: Avalon register word addresses,
// edge-select encodings and interrupt-source encodings.
package testro_pio_pkg;

   localparam int BUS_WIDTH = 32;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   localparam int IRQ_EDGE  = 0;
   localparam int IRQ_LEVEL = 1;

   // Avalon write strobe is active-low and only meaningful while selected.
   function automatic logic busWrite(input logic chipselect, input logic write_n);
      return chipselect & ~write_n;
   endfunction

endpackage

// File: rtl/testro_status_in_pio_if.sv
// Avalon-MM slave bus bundle for the TestRO status input PIO.
interface testro_status_in_pio_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/testro_in_sync_edge.sv
// Multi-flop synchroniser for the status bus plus a one-cycle delayed copy,
// producing the synced level and the selected per-bit edge pulses.
module testro_in_sync_edge
   import testro_pio_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int EDGE_TYPE   = EDGE_RISING,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port_i,
   output logic [WIDTH-1:0] sync_o,
   output logic [WIDTH-1:0] det_o
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];
   logic [WIDTH-1:0] dly_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   // dly_q resets low so a bit held high across reset release reports one rising edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
         dly_q <= '0;
      end else begin
         stage_q[0] <= in_port_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
         dly_q <= stage_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = stage_q[SYNC_STAGES-1];

   always_comb begin
      rise  = sync_o & ~dly_q;
      fall  = ~sync_o & dly_q;
      det_o = rise;
      case (EDGE_TYPE)
         EDGE_FALLING: det_o = fall;
         EDGE_ANY:     det_o = rise | fall;
         default:      det_o = rise;
      endcase
   end

endmodule

// File: rtl/testro_status_in_pio.sv
// Avalon-MM input PIO for TestRO readout status: synced DATA view, sticky
// edge capture with write-1-to-clear, maskable interrupt to the Nios.
module testro_status_in_pio
   import testro_pio_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int EDGE_TYPE   = EDGE_RISING,
   parameter int IRQ_MODE    = IRQ_EDGE,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   testro_status_in_pio_if.slave  bus,
   input  logic [WIDTH-1:0]       in_port,
   output logic                   irq
);

   logic [WIDTH-1:0]     sync;
   logic [WIDTH-1:0]     det;
   logic                 wrEn;
   logic [WIDTH-1:0]     wrBits;
   logic [WIDTH-1:0]     clr;
   logic [WIDTH-1:0]     irqmask_q;
   logic [WIDTH-1:0]     irqmask_d;
   logic [WIDTH-1:0]     cap_q;
   logic [WIDTH-1:0]     cap_d;
   logic [BUS_WIDTH-1:0] readdata_q;
   logic [BUS_WIDTH-1:0] readdata_d;
   logic                 unused_wdata;

   testro_in_sync_edge #(
      .WIDTH       (WIDTH),
      .EDGE_TYPE   (EDGE_TYPE),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_port_i (in_port),
      .sync_o    (sync),
      .det_o     (det)
   );

   assign wrEn         = busWrite(bus.chipselect, bus.write_n);
   assign wrBits       = bus.writedata[WIDTH-1:0];
   assign unused_wdata = ^bus.writedata;

   always_comb begin
      irqmask_d = irqmask_q;
      clr       = '0;
      if (wrEn) begin
         case (bus.address)
            ADDR_IRQMASK: irqmask_d = wrBits;
            ADDR_EDGECAP: clr       = wrBits;
            default:      ;
         endcase
      end
   end

   // A new edge in the same cycle as a clear of that bit keeps the bit set.
   assign cap_d = det | (cap_q & ~clr);

   always_comb begin
      readdata_d = '0;
      if (bus.chipselect) begin
         case (bus.address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = sync;
            ADDR_RSVD:    readdata_d            = '0;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = cap_q;
            default:      readdata_d            = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_q  <= '0;
         cap_q      <= '0;
         readdata_q <= '0;
      end else begin
         irqmask_q  <= irqmask_d;
         cap_q      <= cap_d;
         readdata_q <= readdata_d;
      end
   end

   assign bus.readdata = readdata_q;

   generate
      if (IRQ_MODE == IRQ_LEVEL) begin : gIrqLevel
         assign irq = |(sync & irqmask_q);
      end else begin : gIrqEdge
         assign irq = |(cap_q & irqmask_q);
      end
   endgenerate

endmodule

// File: tb/tb_testro_status_in_pio.sv
// Scoreboard bench: two PIO instances (rising/edge-irq and any/level-irq) share
// one bus and status stream; a cycle-level reference model predicts both.
module tb_testro_status_in_pio;
   import testro_pio_pkg::*;

   localparam int W = 4;
   localparam int S = 2;

   logic          clk        = 1'b0;
   logic          reset_n    = 1'b0;
   logic [1:0]    address    = '0;
   logic          chipselect = 1'b0;
   logic          write_n    = 1'b1;
   logic [31:0]   writedata  = '0;
   logic [W-1:0]  inPort     = '0;
   logic          irqA;
   logic          irqB;

   int errors = 0;
   int checks = 0;

   testro_status_in_pio_if busA ();
   testro_status_in_pio_if busB ();

   assign busA.address    = address;
   assign busA.chipselect = chipselect;
   assign busA.write_n    = write_n;
   assign busA.writedata  = writedata;
   assign busB.address    = address;
   assign busB.chipselect = chipselect;
   assign busB.write_n    = write_n;
   assign busB.writedata  = writedata;

   testro_status_in_pio #(
      .WIDTH(W), .EDGE_TYPE(EDGE_RISING), .IRQ_MODE(IRQ_EDGE), .SYNC_STAGES(S)
   ) dutA (
      .clk(clk), .reset_n(reset_n), .bus(busA.slave), .in_port(inPort), .irq(irqA)
   );

   testro_status_in_pio #(
      .WIDTH(W), .EDGE_TYPE(EDGE_ANY), .IRQ_MODE(IRQ_LEVEL), .SYNC_STAGES(S)
   ) dutB (
      .clk(clk), .reset_n(reset_n), .bus(busB.slave), .in_port(inPort), .irq(irqB)
   );

   always #5 clk = ~clk;

   // Reference model: the synced view is simply the status sample taken S-1
   // edges earlier; captures are bits whose synced value changed since last cycle.
   logic [W-1:0]  mSync;
   logic [W-1:0]  mPrev;
   logic [W-1:0]  mMask;
   logic [W-1:0]  mCap [2];
   logic [W-1:0]  inHist [$];
   logic [31:0]   expRdA [$];
   logic [31:0]   expRdB [$];
   logic [W-1:0]  tChanged;
   logic [W-1:0]  tClr;

   function automatic logic [31:0] modelRead(input int k);
      logic [31:0] v;
      v = 32'd0;
      if (chipselect) begin
         if (address == 2'd0)      v = {28'd0, mSync};
         else if (address == 2'd2) v = {28'd0, mMask};
         else if (address == 2'd3) v = {28'd0, mCap[k]};
      end
      return v;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mSync   = '0;
         mPrev   = '0;
         mMask   = '0;
         mCap[0] = '0;
         mCap[1] = '0;
         inHist.delete();
         for (int i = 0; i < S - 1; i++) inHist.push_back('0);
         expRdA.delete();
         expRdB.delete();
      end else begin
         expRdA.push_back(modelRead(0));
         expRdB.push_back(modelRead(1));
         tChanged = mSync ^ mPrev;
         tClr     = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
         mCap[0]  = (tChanged & mSync) | (mCap[0] & ~tClr);
         mCap[1]  = tChanged | (mCap[1] & ~tClr);
         if (chipselect && !write_n && address == 2'd2) mMask = writedata[W-1:0];
         mPrev = mSync;
         mSync = inHist.pop_front();
         inHist.push_back(inPort);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: pops one predicted readdata per clocked cycle and checks irq levels.
   always @(negedge clk) begin
      if (!reset_n) begin
         checkOutput("rdA_reset", busA.readdata, 32'd0);
         checkOutput("rdB_reset", busB.readdata, 32'd0);
         checkOutput("irqA_reset", {31'd0, irqA}, 32'd0);
         checkOutput("irqB_reset", {31'd0, irqB}, 32'd0);
      end else begin
         if (expRdA.size() > 0) checkOutput("rdA", busA.readdata, expRdA.pop_front());
         if (expRdB.size() > 0) checkOutput("rdB", busB.readdata, expRdB.pop_front());
         checkOutput("irqA", {31'd0, irqA}, {31'd0, |(mCap[0] & mMask)});
         checkOutput("irqB", {31'd0, irqB}, {31'd0, |(mSync & mMask)});
      end
   end

   task automatic applyStimulus(input logic [1:0] a, input logic cs, input logic wr,
                                input logic [31:0] d);
      address    = a;
      chipselect = cs;
      write_n    = ~wr;
      writedata  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(2'd0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      $display("[TB] start");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(3);

      // Reset mid-run with all inputs high, then watch the release capture.
      inPort = 4'hF;
      idle(3);
      reset_n = 1'b0;
      idle(3);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(ADDR_EDGECAP, 1'b1, 1'b0, 32'd0);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b1, 32'hF);

      // Rising capture on bit 2, then drop it.
      inPort = 4'h0;
      idle(4);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b1, 32'hF);
      inPort = 4'b0100;
      idle(4);
      applyStimulus(ADDR_DATA, 1'b1, 1'b0, 32'd0);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b0, 32'd0);
      inPort = 4'h0;
      idle(4);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b0, 32'd0);

      // Mask, no-op clear, real clear.
      applyStimulus(ADDR_IRQMASK, 1'b1, 1'b1, 32'hFFFF_FFF4);
      idle(1);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b1, 32'h0);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b0, 32'd0);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b1, 32'h4);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b0, 32'd0);

      // Edge on bit 2 lands in the same cycle as its clear.
      inPort = 4'b0100;
      idle(4);
      inPort = 4'h0;
      idle(4);
      inPort = 4'b0100;
      idle(2);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b1, 32'h4);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b0, 32'd0);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b0, 32'd0);

      // Toggle bit 0 with only bit 0 unmasked.
      applyStimulus(ADDR_IRQMASK, 1'b1, 1'b1, 32'h1);
      inPort = 4'b0101;
      idle(4);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b0, 32'd0);
      inPort = 4'b0100;
      idle(4);
      applyStimulus(ADDR_EDGECAP, 1'b1, 1'b0, 32'd0);

      // Read protocol corners.
      applyStimulus(ADDR_RSVD, 1'b1, 1'b0, 32'd0);
      applyStimulus(ADDR_RSVD, 1'b1, 1'b1, 32'hFFFF_FFFF);
      applyStimulus(ADDR_EDGECAP, 1'b0, 1'b0, 32'd0);
      applyStimulus(ADDR_DATA, 1'b1, 1'b1, 32'hFFFF_FFFF);
      applyStimulus(ADDR_DATA, 1'b1, 1'b0, 32'd0);
      applyStimulus(ADDR_IRQMASK, 1'b1, 1'b0, 32'd0);
      idle(1);

      // Randomised traffic with occasional status changes and resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) inPort = W'($urandom_range(0, 15));
         if ($urandom_range(0, 199) == 0) begin
            reset_n = 1'b0;
            idle(2);
            reset_n = 1'b1;
         end
         applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0), $urandom);
      end

      idle(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/testro_status_in_pio.md
Name: testro_status_in_pio

Overview:
Avalon-MM slave input PIO for the TestRO readout path. It is the read-back counterpart of the write-enable output PIO. The block synchronises a WIDTH-bit status bus from the readout logic (e.g. readout-done, FIFO-ready) into the clk domain. It records per-bit edges in a sticky edge-capture register and raises a maskable interrupt to the Nios processor.

Parameters:
WIDTH, 1, number of status inputs (1..32)
EDGE_TYPE, 0, edge captured: 0 rising, 1 falling, 2 any
IRQ_MODE, 0, 0 = irq from edgecapture & mask; 1 = irq from synced level & mask
SYNC_STAGES, 2, synchroniser depth (2..3)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
address  in  2  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
in_port  in  WIDTH  asynchronous status inputs
readdata  out  32  registered read data
irq  out  1  interrupt request, active-high

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All of the following are 0 during reset: sync chain, delayed sample, irqmask, edgecapture, readdata and irq.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync[WIDTH-1:0]. A change sampled at edge E0 appears on sync after edge E0+SYNC_STAGES-1.
- Edge detect: the delayed register dly is loaded from sync every cycle.
  - rise = sync & ~dly
  - fall = ~sync & dly
  - det = rise, fall or rise|fall, selected by EDGE_TYPE
- Because dly resets to 0, an input held high through reset release produces one rising-edge capture. This is intended: the processor sees the initial "done" state.
- Register map (word address):
  - 0 DATA: read returns sync, zero-extended to 32 bits. Writes are ignored.
  - 1: reserved. Reads 0; writes are ignored.
  - 2 IRQMASK: read/write, WIDTH bits. Upper writedata bits are ignored.
  - 3 EDGECAPTURE: read returns the sticky bits. A write with writedata[i]=1 clears bit i; 0 leaves it unchanged.
- Write qualifier: chipselect && !write_n. Writes take effect on the next clk edge.
- Read: there is no read strobe. At every edge, readdata is loaded with the mux selected by address while chipselect=1, and with 0 while chipselect=0. Read latency is 1 cycle.
- EDGECAPTURE update per bit, evaluated per clock:
  - next = det[i] | (cap[i] & ~clr[i])
  - A detected edge and a clear of the same bit in the same cycle leaves the bit set (edge wins).
- irq is combinational from registers:
  - IRQ_MODE 0: irq = |(edgecapture & irqmask)
  - IRQ_MODE 1: irq = |(sync & irqmask)
- Reset asserted mid-operation clears pending captures immediately. No capture is generated while reset_n=0.
- Bits above WIDTH read as 0 in every register.

Decomposition:
- Shared package testro_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3
  - EDGE_RISING/FALLING/ANY encodings
  - IRQ_EDGE/IRQ_LEVEL encodings
- One sub-module, testro_in_sync_edge: parameterised synchroniser plus dly register and det generation. Outputs sync and det.
- The top level holds the register file, read mux and irq.

Test Plan:
1. Reset and idle (WIDTH=4): assert reset_n=0 with in_port=4'hF mid-run -> readdata=0, irq=0. Release reset -> within SYNC_STAGES+1 cycles, EDGECAPTURE reads 0x0000000F.
2. Rising capture (WIDTH=4, EDGE_TYPE=0, in_port=0 then 4'b0100) -> DATA reads 0x4 and EDGECAPTURE reads 0x4. Dropping in_port to 0 leaves EDGECAPTURE at 0x4.
3. Mask and clear: write IRQMASK=0x4 -> irq=1 the cycle after the write. Write EDGECAPTURE=0x4 -> cap=0 and irq=0 next cycle. Writing 0x0 instead leaves cap at 0x4.
4. Simultaneous: drive a second rising edge on bit 2 so det asserts in the same cycle as a write-1-clear of bit 2 -> bit 2 remains 1 and irq stays high.
5. EDGE_TYPE=2, IRQ_MODE=1, IRQMASK=0x1: toggle in_port[0] 0->1->0 -> EDGECAPTURE bit 0 is set after each edge. irq follows the synced level: high only while in_port[0]=1, delayed by SYNC_STAGES cycles.
6. Read protocol: read address 1 -> 0x00000000. Read with chipselect=0 -> readdata=0 next cycle. Back-to-back reads of addr 0 then 2 -> each result appears exactly 1 cycle after its address.
